// File: rtl/fpu_round_pack.sv
// Round-and-pack back end for the FPU: pre-normalize by one bit, round (RN/RZ),
// post-normalize and pack an IEEE single through a two-stage valid/ready pipe.
module fpu_round_pack #(
   parameter int EXP_W   = 10,
   parameter int FRAC_W  = 23,
   parameter int EXP_MAX = 255
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic signed [EXP_W-1:0] in_exp,
   input  logic [27:0]             in_mant,
   input  logic                    in_rm,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_data,
   output logic                    out_inexact,
   output logic                    out_overflow,
   output logic                    out_underflow
);

   generate
      if (FRAC_W != 23) begin : g_bad_frac_w
         $error("fpu_round_pack supports FRAC_W = 23 only");
      end
   endgenerate

   localparam logic signed [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_MAX);

   logic                    s1_valid, s2_valid;
   logic                    s1_adv, s2_adv;

   logic                    s1_sign, s1_zero, s1_rm, s1_round_up, s1_inexact;
   logic signed [EXP_W-1:0] s1_exp;
   logic [23:0]             s1_m24;

   logic [31:0]             s2_data;
   logic                    s2_inexact, s2_overflow, s2_underflow;

   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = s2_adv || !s1_valid;
   assign in_ready = s1_adv;

   // Stage 1: pre-normalize, keeping the shifted-out bit in sticky.
   logic [27:0]             mant_n;
   logic signed [EXP_W-1:0] exp_n;
   logic                    lsb, guard, sticky, round_up_d;

   always_comb begin
      mant_n = in_mant;
      exp_n  = in_exp;
      if (in_mant[27]) begin
         mant_n = {1'b0, in_mant[27:2], in_mant[1] | in_mant[0]};
         exp_n  = in_exp + EXP_W'(1);
      end
   end

   assign lsb        = mant_n[3];
   assign guard      = mant_n[2];
   assign sticky     = mant_n[1] | mant_n[0];
   assign round_up_d = !in_rm && guard && (sticky || lsb);

   // Stage 2 datapath from the stage-1 registers.
   logic [24:0]             m25;
   logic signed [EXP_W-1:0] exp_f;
   logic [22:0]             frac_f;
   logic [31:0]             data_d;
   logic                    inexact_d, overflow_d, underflow_d;
   logic                    unused_bits;

   assign m25         = {1'b0, s1_m24} + 25'(s1_round_up);
   assign exp_f       = m25[24] ? s1_exp + EXP_W'(1) : s1_exp;
   assign frac_f      = m25[22:0];
   assign unused_bits = m25[23] ^ mant_n[27];

   always_comb begin
      data_d      = {s1_sign, exp_f[7:0], frac_f};
      inexact_d   = s1_inexact;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (s1_zero) begin
         data_d    = {s1_sign, 31'd0};
         inexact_d = 1'b0;
      end else if (exp_f >= EXP_TOP) begin
         overflow_d = 1'b1;
         inexact_d  = 1'b1;
         data_d     = s1_rm ? {s1_sign, 31'h7F7FFFFF} : {s1_sign, 31'h7F800000};
      end else if (exp_f <= $signed(EXP_W'(0))) begin
         underflow_d = 1'b1;
         inexact_d   = 1'b1;
         data_d      = {s1_sign, 31'd0};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) s2_valid <= s1_valid;
      end
   end

   // Payload registers carry no reset; the outputs are gated by valid instead.
   always_ff @(posedge clk) begin
      if (s1_adv && in_valid) begin
         s1_sign     <= in_sign;
         s1_zero     <= (in_mant == 28'd0);
         s1_rm       <= in_rm;
         s1_exp      <= exp_n;
         s1_m24      <= mant_n[26:3];
         s1_round_up <= round_up_d;
         s1_inexact  <= guard | sticky;
      end
      if (s2_adv && s1_valid) begin
         s2_data      <= data_d;
         s2_inexact   <= inexact_d;
         s2_overflow  <= overflow_d;
         s2_underflow <= underflow_d;
      end
   end

   assign out_valid     = s2_valid;
   assign out_data      = s2_valid ? s2_data : 32'd0;
   assign out_inexact   = s2_valid && s2_inexact;
   assign out_overflow  = s2_valid && s2_overflow;
   assign out_underflow = s2_valid && s2_underflow;

endmodule

// File: tb/tb_fpu_round_pack.sv
// Directed bench for fpu_round_pack: rounding/packing vectors, backpressure
// streaming, flush and reset mid-stream.
module tb_fpu_round_pack;

   logic              clk = 1'b0;
   logic              rstn, flush, in_valid, in_ready, in_sign, in_rm;
   logic signed [9:0] in_exp;
   logic [27:0]       in_mant;
   logic              out_valid, out_ready, out_inexact, out_overflow, out_underflow;
   logic [31:0]       out_data;

   int passed = 0;
   int fails  = 0;
   int total  = 0;

   always #5 clk = ~clk;

   fpu_round_pack dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_rm(in_rm),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_inexact(out_inexact), .out_overflow(out_overflow),
      .out_underflow(out_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [2:0] flags();
      return {out_inexact, out_overflow, out_underflow};
   endfunction

   // One isolated beat: flags are {inexact, overflow, underflow}.
   task automatic send(input string tag, input logic sgn, input logic signed [9:0] e,
                       input logic [27:0] m, input logic rm,
                       input logic [31:0] xd, input logic [2:0] xf);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_sign   = sgn;
      in_exp    = e;
      in_mant   = m;
      in_rm     = rm;
      #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk({tag, "_valid_c1"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1 chk({tag, "_valid_c2"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, out_data, xd);
      chk({tag, "_flags"}, 32'(flags()), 32'(xf));
   endtask

   function automatic logic [31:0] stream_exp(input int i);
      return {i[0], 8'(100 + i), 23'(i)};
   endfunction

   task automatic fill_two();
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sign   = 1'b0;
      in_exp    = 10'sd120;
      in_mant   = 28'h4000000;
      in_rm     = 1'b0;
      @(negedge clk);
      in_exp    = 10'sd121;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      int          tx, rx;
      logic        hold_chk;
      logic [31:0] held;

      rstn      = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      in_rm     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_flags", 32'(flags()), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rstn = 1'b1;

      send("basic",      1'b0, 10'sd127, 28'h4000000, 1'b0, 32'h3F800000, 3'b000);
      send("tie_rn_odd", 1'b0, 10'sd127, 28'h400000C, 1'b0, 32'h3F800002, 3'b100);
      send("tie_rz",     1'b0, 10'sd127, 28'h400000C, 1'b1, 32'h3F800001, 3'b100);
      send("tie_rn_evn", 1'b0, 10'sd127, 28'h4000004, 1'b0, 32'h3F800000, 3'b100);
      send("rnd_carry",  1'b0, 10'sd127, 28'h7FFFFFC, 1'b0, 32'h40000000, 3'b100);
      send("pre_norm",   1'b0, 10'sd127, 28'h8000000, 1'b0, 32'h40000000, 3'b000);
      send("pre_sticky", 1'b0, 10'sd127, 28'h8000009, 1'b0, 32'h40000001, 3'b100);
      send("rnd_gs",     1'b1, 10'sd130, 28'h4000006, 1'b0, 32'hC1000001, 3'b100);
      send("ovf_rn",     1'b0, 10'sd255, 28'h4000000, 1'b0, 32'h7F800000, 3'b110);
      send("ovf_rz",     1'b0, 10'sd255, 28'h4000000, 1'b1, 32'h7F7FFFFF, 3'b110);
      send("ovf_carry",  1'b0, 10'sd254, 28'h7FFFFFC, 1'b0, 32'h7F800000, 3'b110);
      send("max_rz",     1'b0, 10'sd254, 28'h7FFFFFC, 1'b1, 32'h7F7FFFFF, 3'b100);
      send("unf_neg",    1'b1, 10'sd0,   28'h4000000, 1'b0, 32'h80000000, 3'b101);
      send("unf_minus",  1'b0, -10'sd5,  28'h4000000, 1'b0, 32'h00000000, 3'b101);
      send("min_norm",   1'b0, 10'sd1,   28'h4000000, 1'b0, 32'h00800000, 3'b000);
      send("norm_to_1",  1'b0, 10'sd0,   28'h8000000, 1'b0, 32'h00800000, 3'b000);
      send("zero_neg",   1'b1, 10'sd50,  28'h0000000, 1'b0, 32'h80000000, 3'b000);
      send("zero_big",   1'b0, 10'sd300, 28'h0000000, 1'b0, 32'h00000000, 3'b000);

      // Back-to-back stream with out_ready pattern 1,0,0,1.
      @(posedge clk);
      tx = 0;
      rx = 0;
      hold_chk = 1'b0;
      held = '0;
      for (int c = 0; c < 60 && rx < 6; c++) begin
         @(negedge clk);
         if (hold_chk) chk("stall_hold", out_data, held);
         out_ready = (c % 4 == 0) || (c % 4 == 3);
         in_valid  = (tx < 6);
         in_sign   = tx[0];
         in_exp    = 10'(100 + tx);
         in_mant   = 28'h4000000 | (28'(tx) << 3);
         in_rm     = 1'b0;
         #1;
         if (tx - rx == 2 && !out_ready) chk("full_in_ready", 32'(in_ready), 32'd0);
         hold_chk = out_valid && !out_ready;
         held     = out_data;
         if (out_valid && out_ready) begin
            chk("stream_data", out_data, stream_exp(rx));
            rx++;
         end
         if (in_valid && in_ready) tx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_rx_count", 32'(rx), 32'd6);
      repeat (2) @(posedge clk);
      #1 chk("stream_no_dup", 32'(out_valid), 32'd0);

      // Flush with two beats in flight; the flush-cycle input is dropped too.
      fill_two();
      chk("fl_full_valid", 32'(out_valid), 32'd1);
      chk("fl_full_rdy", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1 chk("fl_rdy_comb", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_exp   = 10'sd122;
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 chk("fl_no_beat", 32'(out_valid), 32'd0);
      end

      // Reset mid-stream, flush asserted too (reset wins; both clear).
      fill_two();
      chk("rs_full_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      rstn  = 1'b0;
      flush = 1'b1;
      @(posedge clk);
      #1;
      chk("rs_valid", 32'(out_valid), 32'd0);
      chk("rs_data", out_data, 32'd0);
      chk("rs_flags", 32'(flags()), 32'd0);
      @(negedge clk);
      rstn  = 1'b1;
      flush = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 chk("rs_no_beat", 32'(out_valid), 32'd0);
      send("after_rst", 1'b1, 10'sd128, 28'h4000000, 1'b0, 32'hC0000000, 3'b000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
